// File: rtl/mod12_loadable_updown_counter.sv
// Loadable up/down counter modulo MODULUS with asynchronous active-low reset.
// One register stage; data_out is always in 0..MODULUS-1.
module mod12_loadable_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode,
    input  logic             load,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             load_in_range;
    logic             count_in_range;

    assign load_in_range  = (data_in <= MAX_VAL);
    assign count_in_range = (count_q <= MAX_VAL);

    // Next value: load wins over count; any out-of-range value collapses to 0.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_in_range ? data_in : ZERO_VAL;
        end else if (!count_in_range) begin
            count_d = ZERO_VAL;
        end else if (mode) begin
            count_d = (count_q == MAX_VAL) ? ZERO_VAL : count_q + ONE_VAL;
        end else begin
            count_d = (count_q == ZERO_VAL) ? MAX_VAL : count_q - ONE_VAL;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= ZERO_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign data_out = count_q;

endmodule

// File: tb/tb_mod12_loadable_updown_counter.sv
// Directed self-checking bench for mod12_loadable_updown_counter.
module tb_mod12_loadable_updown_counter;

    logic       clock;
    logic       reset;
    logic [3:0] data_in;
    logic       mode;
    logic       load;
    logic [3:0] data_out;

    int total;
    int bad;

    int exp_up   [13] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 1};
    int exp_down [3]  = '{11, 10, 9};
    int exp_res  [5]  = '{8, 9, 10, 11, 0};
    int dir_mode [5]  = '{1, 1, 0, 0, 0};
    int exp_dir  [5]  = '{4, 5, 4, 3, 2};

    mod12_loadable_updown_counter #(.WIDTH(4), .MODULUS(12)) dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .mode     (mode),
        .load     (load),
        .data_out (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle at the following falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_load(input logic [3:0] val, input logic m);
        load    = 1'b1;
        mode    = m;
        data_in = val;
        step();
        load    = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        load    = 1'b0;
        mode    = 1'b1;
        data_in = 4'd0;

        #1 reset = 1'b0;
        #1 check("reset_async", data_out, 4'd0);
        @(negedge clock);
        check("reset_hold", data_out, 4'd0);

        // Count up with wrap
        reset = 1'b1;
        mode  = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            check($sformatf("up_%0d", i), data_out, 4'(exp_up[i]));
        end

        // Asynchronous reset between edges while counting
        #2 reset = 1'b0;
        #1 check("reset_midcount", data_out, 4'd0);
        step();
        check("reset_low_edge", data_out, 4'd0);

        // Count down with wrap from reset
        reset = 1'b1;
        mode  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("down_%0d", i), data_out, 4'(exp_down[i]));
        end

        // Load then resume counting up
        do_load(4'd7, 1'b1);
        check("load_7", data_out, 4'd7);
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("resume_%0d", i), data_out, 4'(exp_res[i]));
        end

        // Load beats decrement; out-of-range loads zero
        do_load(4'd5, 1'b0);
        check("load_prio", data_out, 4'd5);
        do_load(4'd14, 1'b0);
        check("load_oor14", data_out, 4'd0);
        do_load(4'd12, 1'b1);
        check("load_oor12", data_out, 4'd0);
        do_load(4'd11, 1'b1);
        check("load_max", data_out, 4'd11);
        mode = 1'b1;
        step();
        check("wrap_up_from_load", data_out, 4'd0);
        mode = 1'b0;
        step();
        check("wrap_down_zero", data_out, 4'd11);

        // Direction change from 3
        do_load(4'd3, 1'b1);
        check("load_3", data_out, 4'd3);
        for (int i = 0; i < 5; i++) begin
            mode = dir_mode[i][0];
            step();
            check($sformatf("dir_%0d", i), data_out, 4'(exp_dir[i]));
        end

        // Reset during a pending load discards it
        load    = 1'b1;
        data_in = 4'd9;
        #2 reset = 1'b0;
        #1 check("reset_during_load", data_out, 4'd0);
        step();
        check("reset_load_edge", data_out, 4'd0);
        load  = 1'b0;
        mode  = 1'b1;
        reset = 1'b1;
        step();
        check("post_reset_up", data_out, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
